cordic_step_engine: RTL and testbench

Single-step CORDIC rotation datapath: the consumer end of the button-driven step controller. It latches an initial vector and angle, then executes exactly one CORDIC micro-rotation per accepted step request, using the supplied iteration index. Results are visible after every step, so a user can walk the algorithm on the FPGA board one iteration at a time.

---
 rtl/cordic_step_if.sv | 28 ++
 rtl/cordic_step_engine.sv | 141 ++++++++++++++
 tb/tb_cordic_step_engine.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_step_if.sv
// Handshake/data bundle between the step controller (master) and the CORDIC step engine (slave).
interface cordic_step_if #(
    parameter int W = 16
);
    logic                load;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic signed [W-1:0] z_in;
    logic                step;
    logic [3:0]          step_idx;
    logic signed [W-1:0] x_out;
    logic signed [W-1:0] y_out;
    logic signed [W-1:0] z_out;
    logic [4:0]          iter_cnt;
    logic                busy;
    logic                done;
    logic                seq_err;

    modport master (
        output load, x_in, y_in, z_in, step, step_idx,
        input  x_out, y_out, z_out, iter_cnt, busy, done, seq_err
    );

    modport slave (
        input  load, x_in, y_in, z_in, step, step_idx,
        output x_out, y_out, z_out, iter_cnt, busy, done, seq_err
    );
endinterface

// File: rtl/cordic_step_engine.sv
// Single-step CORDIC rotation engine: one micro-rotation per accepted step request.
// Define CORDIC_SEQ_CHECK_EN to require step_idx == iter_cnt and flag mismatches in seq_err.
module cordic_step_engine #(
    parameter int W    = 16,
    parameter int ITER = 16
) (
    input  logic          clk,
    input  logic          reset,
    cordic_step_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, READY, SHF, UPD, DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic signed [W-1:0] r_x, r_y, r_z;
    logic signed [W-1:0] r_xs, r_ys, r_at;
    logic                r_d;
    logic [3:0]          r_idx;
    logic [4:0]          r_cnt;
    logic                r_seq_err;
    logic                w_load_acc;
    logic                w_step_acc;
    logic                w_step_bad;
    logic                w_idx_ok;

    function automatic logic signed [W-1:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = W'(6434);
            4'd1:    atan_lut = W'(3798);
            4'd2:    atan_lut = W'(2007);
            4'd3:    atan_lut = W'(1019);
            4'd4:    atan_lut = W'(511);
            4'd5:    atan_lut = W'(256);
            4'd6:    atan_lut = W'(128);
            4'd7:    atan_lut = W'(64);
            4'd8:    atan_lut = W'(32);
            4'd9:    atan_lut = W'(16);
            4'd10:   atan_lut = W'(8);
            4'd11:   atan_lut = W'(4);
            4'd12:   atan_lut = W'(2);
            4'd13:   atan_lut = W'(1);
            default: atan_lut = '0;
        endcase
    endfunction

`ifdef CORDIC_SEQ_CHECK_EN
    assign w_idx_ok = (bus.step_idx == r_cnt[3:0]);
`else
    assign w_idx_ok = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load_acc  = 1'b0;
        w_step_acc  = 1'b0;
        w_step_bad  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.load) begin
                    w_load_acc  = 1'b1;
                    w_state_nxt = READY;
                end
            end
            READY: begin
                if (bus.load) begin
                    w_load_acc  = 1'b1;
                    w_state_nxt = READY;
                end else if (bus.step) begin
                    if (w_idx_ok) begin
                        w_step_acc  = 1'b1;
                        w_state_nxt = SHF;
                    end else begin
                        w_step_bad  = 1'b1;
                    end
                end
            end
            SHF:     w_state_nxt = UPD;
            UPD:     w_state_nxt = (r_cnt + 5'd1 == 5'(ITER)) ? DONE : READY;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Reset clears the datapath too, so a step interrupted in SHF/UPD leaves nothing behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_xs      <= '0;
            r_ys      <= '0;
            r_at      <= '0;
            r_d       <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_seq_err <= 1'b0;
        end else begin
            if (w_load_acc) begin
                r_x       <= bus.x_in;
                r_y       <= bus.y_in;
                r_z       <= bus.z_in;
                r_cnt     <= '0;
                r_seq_err <= 1'b0;
            end
            if (w_step_acc) r_idx <= bus.step_idx;
            if (w_step_bad) r_seq_err <= 1'b1;
            if (r_state == SHF) begin
                r_xs <= r_x >>> r_idx;
                r_ys <= r_y >>> r_idx;
                r_at <= atan_lut(r_idx);
                r_d  <= ~r_z[W-1];
            end
            if (r_state == UPD) begin
                if (r_d) begin
                    r_x <= r_x - r_ys;
                    r_y <= r_y + r_xs;
                    r_z <= r_z - r_at;
                end else begin
                    r_x <= r_x + r_ys;
                    r_y <= r_y - r_xs;
                    r_z <= r_z + r_at;
                end
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    assign bus.x_out    = r_x;
    assign bus.y_out    = r_y;
    assign bus.z_out    = r_z;
    assign bus.iter_cnt = r_cnt;
    assign bus.busy     = (r_state == SHF) || (r_state == UPD);
    assign bus.done     = (r_state == DONE);
    assign bus.seq_err  = r_seq_err;

endmodule

// File: tb/tb_cordic_step_engine.sv
// Bench for cordic_step_engine: spec vector table, hand-written corner sequences, randomized walks vs. a reference model.
module tb_cordic_step_engine;
    localparam int W    = 16;
    localparam int ITER = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cordic_step_if #(.W(W)) bus();
    cordic_step_engine #(.W(W), .ITER(ITER)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int mx, my, mz, mcnt;
    bit merr, midle;

    typedef struct {
        int x, y, z, nsteps;
        int ex, ey, ez, tol_xy, tol_z;
        bit edone;
    } vec_t;

    function automatic int wrapw(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    function automatic int atan_ref(input int i);
        real a;
        a = $atan(2.0 ** (-i)) * 8192.0;
        return $rtoi(a + 0.5);
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mz = 0; mcnt = 0; merr = 1'b0; midle = 1'b1;
    endtask

    task automatic model_step(input int idx);
        int xs, ys;
        if (midle || mcnt == ITER) return;
`ifdef CORDIC_SEQ_CHECK_EN
        if (idx != (mcnt % 16)) begin
            merr = 1'b1;
            return;
        end
`endif
        xs = mx >>> idx;
        ys = my >>> idx;
        if (mz >= 0) begin
            mx = wrapw(mx - ys); my = wrapw(my + xs); mz = wrapw(mz - atan_ref(idx));
        end else begin
            mx = wrapw(mx + ys); my = wrapw(my - xs); mz = wrapw(mz + atan_ref(idx));
        end
        mcnt++;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_tol(input string nm, input int act, input int exp, input int tol);
        n_vec++;
        if (act - exp > tol || exp - act > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".x"}, int'(bus.x_out), mx);
        check({tag, ".y"}, int'(bus.y_out), my);
        check({tag, ".z"}, int'(bus.z_out), mz);
        check({tag, ".cnt"}, int'(bus.iter_cnt), mcnt);
        check({tag, ".done"}, int'(bus.done), int'(mcnt == ITER && !midle));
        check({tag, ".seq_err"}, int'(bus.seq_err), int'(merr));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_load(input int x, input int y, input int z);
        bus.load = 1'b1;
        bus.x_in = W'(x);
        bus.y_in = W'(y);
        bus.z_in = W'(z);
        tick();
        bus.load = 1'b0;
        mx = wrapw(x); my = wrapw(y); mz = wrapw(z);
        mcnt = 0; merr = 1'b0; midle = 1'b0;
    endtask

    task automatic do_step(input int idx, output int busy_cycles);
        bus.step     = 1'b1;
        bus.step_idx = 4'(idx);
        tick();
        bus.step = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 8 && bus.busy; k++) begin
            busy_cycles++;
            tick();
        end
        if (bus.busy) begin
            n_vec++;
            n_err++;
            $display("FAIL step_timeout: busy still %0d, expected 0", bus.busy);
        end
        model_step(idx);
    endtask

    vec_t tbl[3];
    int   bc;

    initial begin
        bus.load = 1'b0; bus.step = 1'b0; bus.step_idx = '0;
        bus.x_in = '0;   bus.y_in = '0;   bus.z_in = '0;
        tbl[0] = '{4975, 0, 0,    16, 8192, 0,    0,     8, 4, 1'b1};
        tbl[1] = '{4975, 0, 6434, 16, 5793, 5793, 0,     8, 4, 1'b1};
        tbl[2] = '{4975, 0, 100,  1,  4975, 4975, -6334, 0, 0, 1'b0};

        do_reset();
        check("rst.x", int'(bus.x_out), 0);
        check("rst.y", int'(bus.y_out), 0);
        check("rst.z", int'(bus.z_out), 0);
        check("rst.cnt", int'(bus.iter_cnt), 0);
        check("rst.busy", int'(bus.busy), 0);
        check("rst.done", int'(bus.done), 0);
        check("rst.seq_err", int'(bus.seq_err), 0);
        do_step(0, bc);
        check("idle_step.busy", bc, 0);
        check_model("idle_step");

        foreach (tbl[t]) begin
            do_load(tbl[t].x, tbl[t].y, tbl[t].z);
            check_model($sformatf("tbl%0d.load", t));
            for (int i = 0; i < tbl[t].nsteps; i++) begin
                do_step(i, bc);
                check($sformatf("tbl%0d.busy%0d", t, i), bc, 2);
            end
            check_tol($sformatf("tbl%0d.xout", t), int'(bus.x_out), tbl[t].ex, tbl[t].tol_xy);
            check_tol($sformatf("tbl%0d.yout", t), int'(bus.y_out), tbl[t].ey, tbl[t].tol_xy);
            check_tol($sformatf("tbl%0d.zout", t), int'(bus.z_out), tbl[t].ez, tbl[t].tol_z);
            check($sformatf("tbl%0d.done", t), int'(bus.done), int'(tbl[t].edone));
            check($sformatf("tbl%0d.cnt", t), int'(bus.iter_cnt), tbl[t].nsteps);
            check_model($sformatf("tbl%0d.model", t));
            if (tbl[t].edone) begin
                do_step(5, bc);
                check($sformatf("tbl%0d.done_step_busy", t), bc, 0);
                check_model($sformatf("tbl%0d.done_step", t));
            end
        end

        // Step latency: data moves only at the second edge after the step is sampled
        do_load(4975, 0, 100);
        bus.step = 1'b1; bus.step_idx = 4'd0;
        tick();
        bus.step = 1'b0;
        check("lat.e0.busy", int'(bus.busy), 1);
        check("lat.e0.y", int'(bus.y_out), 0);
        tick();
        check("lat.e1.busy", int'(bus.busy), 1);
        check("lat.e1.cnt", int'(bus.iter_cnt), 0);
        tick();
        check("lat.e2.busy", int'(bus.busy), 0);
        model_step(0);
        check_model("lat.e2");

        // Out-of-order index
        do_load(100, 200, 300);
        do_step(3, bc);
`ifdef CORDIC_SEQ_CHECK_EN
        check("seq.bad_busy", bc, 0);
        check("seq.bad_flag", int'(bus.seq_err), 1);
`else
        check("seq.bad_busy", bc, 2);
        check("seq.bad_flag", int'(bus.seq_err), 0);
`endif
        check_model("seq.bad");
        do_step(int'(bus.iter_cnt), bc);
        check_model("seq.next");
        do_load(100, 200, 300);
        check("seq.cleared", int'(bus.seq_err), 0);

        // Step held for three cycles counts once
        bus.step = 1'b1; bus.step_idx = 4'd0;
        tick(); tick(); tick();
        bus.step = 1'b0;
        check("held.busy", int'(bus.busy), 0);
        model_step(0);
        check_model("held");

        // Reset while in UPD discards the partial step
        bus.step = 1'b1; bus.step_idx = 4'd1;
        tick();
        bus.step = 1'b0;
        tick();
        check("rstupd.busy_before", int'(bus.busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("rstupd.busy", int'(bus.busy), 0);
        check_model("rstupd");
        do_step(0, bc);
        check("rstupd.step_busy", bc, 0);
        check_model("rstupd.step");

        // Randomized walks
        for (int r = 0; r < 8; r++) begin
            do_load(int'($urandom_range(8000)) - 4000, int'($urandom_range(8000)) - 4000,
                    int'($urandom_range(24000)) - 12000);
            for (int s = 0; s < ITER + 4; s++) begin
                int idx;
                idx = ($urandom_range(9) == 0) ? int'($urandom_range(15)) : (mcnt % 16);
                do_step(idx, bc);
                check_model($sformatf("rnd%0d.%0d", r, s));
                for (int g = int'($urandom_range(2)); g > 0; g--) tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
